// File: rtl/async_link_pkg.sv
// Shared types and default sizing for the asynchronous link transmitter.
package async_link_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_STALL,
    ST_WAIT_TAIL,
    ST_CLOSE
  } tx_state_t;

endpackage

// File: rtl/async_link_tx_fifo.sv
// Synchronous flit FIFO, no fall-through; a push while full is dropped even
// if a pop happens in the same cycle.
module flit_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates all reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/async_link_tx.sv
// Two-phase bundled-data link transmitter: buffers local flits and sends
// each one as a req_o toggle, waiting for the synchronised ack phase.
module async_link_tx
  import async_link_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flit_valid_i,
  input  logic [WIDTH-1:0] flit_data_i,
  input  logic             flit_last_i,
  output logic             flit_ready_o,
  output logic             req_o,
  output logic [WIDTH-1:0] Data_o,
  input  logic             ack_i,
  output logic             PacketEnable_o,
  input  logic             Tailpassed_i,
  output logic             busy_o
);

  tx_state_t state, state_n;

  logic             ack_meta, ack_s;
  logic             tail_meta, tail_s;
  logic             req_q, req_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             pe_q, pe_n;
  logic             last_q, last_n;
  logic             pop;
  logic [WIDTH:0]   head;
  logic             fifo_full, fifo_empty;

  flit_fifo #(
    .WIDTH(WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (flit_valid_i),
    .wdata({flit_last_i, flit_data_i}),
    .pop  (pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign flit_ready_o   = !fifo_full;
  assign req_o          = req_q;
  assign Data_o         = data_q;
  assign PacketEnable_o = pe_q;
  assign busy_o         = (state != ST_IDLE);

  // Two-flop synchronisers for the asynchronous network-side inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_meta  <= 1'b0;
      ack_s     <= 1'b0;
      tail_meta <= 1'b0;
      tail_s    <= 1'b0;
    end else begin
      ack_meta  <= ack_i;
      ack_s     <= ack_meta;
      tail_meta <= Tailpassed_i;
      tail_s    <= tail_meta;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      req_q  <= 1'b0;
      data_q <= '0;
      pe_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state  <= state_n;
      req_q  <= req_n;
      data_q <= data_n;
      pe_q   <= pe_n;
      last_q <= last_n;
    end
  end

  // Next-state logic; Data_o is loaded only on a pop so it is stable for a
  // full cycle before the REQ state toggles req_o.
  always_comb begin
    state_n = state;
    req_n   = req_q;
    data_n  = data_q;
    pe_n    = pe_q;
    last_n  = last_q;
    pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_n  = head[WIDTH-1:0];
          last_n  = head[WIDTH];
          pe_n    = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        req_n   = !req_q;
        state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_s == req_q) begin
          if (last_q) begin
            state_n = ST_WAIT_TAIL;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            data_n  = head[WIDTH-1:0];
            last_n  = head[WIDTH];
            state_n = ST_REQ;
          end else begin
            state_n = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_n  = head[WIDTH-1:0];
          last_n  = head[WIDTH];
          state_n = ST_REQ;
        end
      end
      ST_WAIT_TAIL: begin
        if (tail_s) begin
          pe_n    = 1'b0;
          state_n = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        if (!tail_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_async_link_tx.sv
// Directed bench for async_link_tx with a behavioural network responder.
module tb_async_link_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        flit_valid;
  logic [31:0] flit_data;
  logic        flit_last;
  logic        flit_ready;
  logic        req;
  logic [31:0] data;
  logic        ack;
  logic        pkt_en;
  logic        tail;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // network responder controls
  bit auto_ack  = 1'b0;
  int ack_delay = 0;

  // observation queues
  logic [31:0] tog_data[$];
  logic [31:0] chg_data[$];
  logic        prev_req  = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 clk = ~clk;

  async_link_tx #(
    .WIDTH(32),
    .DEPTH(4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flit_valid_i  (flit_valid),
    .flit_data_i   (flit_data),
    .flit_last_i   (flit_last),
    .flit_ready_o  (flit_ready),
    .req_o         (req),
    .Data_o        (data),
    .ack_i         (ack),
    .PacketEnable_o(pkt_en),
    .Tailpassed_i  (tail),
    .busy_o        (busy)
  );

  // Record Data_o at every req edge and every Data_o change, shortly after the clock edge.
  always @(posedge clk) begin
    #2;
    if (req !== prev_req) begin
      tog_data.push_back(data);
      prev_req = req;
    end
    if (data !== prev_data) begin
      chg_data.push_back(data);
      prev_data = data;
    end
  end

  // Network side: echo req onto ack after ack_delay cycles.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (auto_ack && (ack !== req)) begin
        if (cnt >= ack_delay) begin
          ack = req;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sig(input int code);
    case (code)
      0:       return int'(pkt_en);
      1:       return int'(req);
      2:       return int'(busy);
      3:       return int'(flit_ready);
      default: return tog_data.size();
    endcase
  endfunction

  // Bounded wait on an observed value; an expired bound reports as a failed check.
  task automatic wait_until(input string tag, input int code, input int val, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sig(code) == val) break;
      @(negedge clk);
    end
    check_eq(tag, 64'(sig(code)), 64'(val));
  endtask

  task automatic push_flit(input logic [31:0] d, input logic l);
    flit_valid = 1'b1;
    flit_data  = d;
    flit_last  = l;
    for (int i = 0; i < 200; i++) begin
      if (flit_ready) begin
        @(negedge clk);
        flit_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    flit_valid = 1'b0;
    check_eq("push_timeout", 64'(flit_ready), 64'd1);
  endtask

  task automatic clear_mon();
    tog_data.delete();
    chg_data.delete();
  endtask

  task automatic close_packet(input string tag);
    repeat (10) @(negedge clk);
    check_eq({tag, "_pe_before_tail"}, 64'(pkt_en), 64'd1);
    tail = 1'b1;
    wait_until({tag, "_pe_clear"}, 0, 0, 20);
    repeat (2) @(negedge clk);
    tail = 1'b0;
    wait_until({tag, "_idle"}, 2, 0, 20);
  endtask

  initial begin
    rst        = 1'b1;
    flit_valid = 1'b0;
    flit_data  = '0;
    flit_last  = 1'b0;
    ack        = 1'b0;
    tail       = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check_eq("rst_req",   64'(req),        64'd0);
    check_eq("rst_data",  64'(data),       64'd0);
    check_eq("rst_pe",    64'(pkt_en),     64'd0);
    check_eq("rst_busy",  64'(busy),       64'd0);
    check_eq("rst_ready", 64'(flit_ready), 64'd1);

    // single-flit packet, ack after 3 cycles
    clear_mon();
    auto_ack  = 1'b1;
    ack_delay = 3;
    push_flit(32'hA5A5_A5A5, 1'b1);
    wait_until("t1_pe_set", 0, 1, 10);
    check_eq("t1_data_before_edge", 64'(data), 64'hA5A5_A5A5);
    check_eq("t1_req_not_yet",      64'(tog_data.size()), 64'd0);
    wait_until("t1_req_edge", 4, 1, 10);
    check_eq("t1_req_high", 64'(req), 64'd1);
    close_packet("t1");
    check_eq("t1_toggles", 64'(tog_data.size()), 64'd1);

    // 4-flit packet, immediate ack
    clear_mon();
    ack_delay = 0;
    for (int i = 1; i <= 4; i++) push_flit(32'(i), (i == 4));
    wait_until("t2_toggles", 4, 4, 100);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_req_data%0d", i), 64'(tog_data[i]), 64'(i + 1));
      check_eq($sformatf("t2_chg_data%0d", i), 64'(chg_data[i]), 64'(i + 1));
    end
    close_packet("t2");
    check_eq("t2_total_toggles", 64'(tog_data.size()), 64'd4);
    check_eq("t2_total_changes", 64'(chg_data.size()), 64'd4);

    // FIFO full with ack held
    clear_mon();
    auto_ack = 1'b0;
    push_flit(32'h20, 1'b0);
    wait_until("t3_head_sent", 4, 1, 20);
    for (int i = 1; i <= 4; i++) push_flit(32'h20 + 32'(i), 1'b0);
    check_eq("t3_full", 64'(flit_ready), 64'd0);
    flit_valid = 1'b1;
    flit_data  = 32'h25;
    flit_last  = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("t3_full_hold", 64'(flit_ready), 64'd0);
    check_eq("t3_data_hold", 64'(data),       64'h20);
    check_eq("t3_one_toggle", 64'(tog_data.size()), 64'd1);
    auto_ack = 1'b1;
    push_flit(32'h25, 1'b1);
    wait_until("t3_toggles", 4, 6, 100);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("t3_req_data%0d", i), 64'(tog_data[i]), 64'h20 + 64'(i));
    close_packet("t3");

    // head only, tail delayed: STALL
    clear_mon();
    push_flit(32'h30, 1'b0);
    wait_until("t4_head_sent", 4, 1, 20);
    repeat (10) @(negedge clk);
    check_eq("t4_pe_stall",   64'(pkt_en), 64'd1);
    check_eq("t4_req_stable", 64'(tog_data.size()), 64'd1);
    check_eq("t4_busy",       64'(busy), 64'd1);
    push_flit(32'h31, 1'b1);
    wait_until("t4_tail_sent", 4, 2, 20);
    check_eq("t4_tail_data", 64'(tog_data[1]), 64'h31);
    close_packet("t4");

    // reset during WAIT_ACK of flit 2
    clear_mon();
    ack_delay = 20;
    push_flit(32'h40, 1'b0);
    push_flit(32'h41, 1'b0);
    push_flit(32'h42, 1'b1);
    wait_until("t5_flit2_sent", 4, 2, 200);
    rst      = 1'b1;
    auto_ack = 1'b0;
    ack      = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_req",   64'(req),        64'd0);
    check_eq("t5_pe",    64'(pkt_en),     64'd0);
    check_eq("t5_busy",  64'(busy),       64'd0);
    check_eq("t5_data",  64'(data),       64'd0);
    check_eq("t5_ready", 64'(flit_ready), 64'd1);
    repeat (5) @(negedge clk);
    check_eq("t5_fifo_dropped", 64'(busy), 64'd0);
    check_eq("t5_pe_quiet",     64'(pkt_en), 64'd0);

    // back-to-back packets, Tailpassed high 5 cycles
    clear_mon();
    ack_delay = 0;
    auto_ack  = 1'b1;
    push_flit(32'h50, 1'b1);
    push_flit(32'h60, 1'b1);
    wait_until("t6_first_sent", 4, 1, 20);
    repeat (6) @(negedge clk);
    tail = 1'b1;
    wait_until("t6_pe_clear", 0, 0, 20);
    repeat (2) @(negedge clk);
    check_eq("t6_no_second_while_tail", 64'(tog_data.size()), 64'd1);
    tail = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t6_head2_held", 64'(data), 64'h50);
    check_eq("t6_busy_close", 64'(busy), 64'd1);
    wait_until("t6_second_sent", 4, 2, 20);
    check_eq("t6_second_data", 64'(tog_data[1]), 64'h60);
    close_packet("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/async_link_tx.md
ASYNC_LINK_TX -- requirements
Module: async_link_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bundled-data flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, local flit FIFO entries; power of two, >=2.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flit_valid_i  input  1  local flit offered.
REQ-006 SHALL have port flit_data_i  input  WIDTH  local flit payload.
REQ-007 SHALL have port flit_last_i  input  1  offered flit is packet tail.
REQ-008 SHALL have port flit_ready_o  output  1  FIFO not full; push when valid&ready.
REQ-009 SHALL have port req_o  output  1  2-phase request toward network; each toggle is one flit.
REQ-010 SHALL have port Data_o  output  WIDTH  bundled data, registered.
REQ-011 SHALL have port ack_i  input  1  2-phase ack from network, asynchronous to clk_i.
REQ-012 SHALL have port PacketEnable_o  output  1  high for the whole packet, head to tail release.
REQ-013 SHALL have port Tailpassed_i  input  1  level from network, high once tail has left downstream, asynchronous.
REQ-014 SHALL have port busy_o  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL pass ack_i and Tailpassed_i each through a 2-flop synchronizer (ack_s, tail_s) before any use.
REQ-016 SHALL store {last, data} in a DEPTH-entry FIFO; push ignored when full even if a pop occurs the same cycle; no fall-through (pushed flit poppable next cycle earliest).
REQ-017 SHALL implement states IDLE, REQ, WAIT_ACK, STALL, WAIT_TAIL, CLOSE.
REQ-018 IDLE: if FIFO non-empty, pop head into Data_o, set PacketEnable_o=1, go REQ; else stay.
REQ-019 REQ: toggle req_o, go WAIT_ACK; guarantees Data_o stable >=1 cycle before req_o edge.
REQ-020 WAIT_ACK: hold Data_o and req_o until ack_s == req_o; then if current flit is last go WAIT_TAIL, else if FIFO non-empty pop next into Data_o and go REQ, else go STALL.
REQ-021 STALL: PacketEnable_o stays 1; on FIFO non-empty pop into Data_o, go REQ.
REQ-022 WAIT_TAIL: when tail_s==1, clear PacketEnable_o, go CLOSE.
REQ-023 CLOSE: when tail_s==0, go IDLE; next packet cannot start before this.
REQ-024 Data_o SHALL change only on a pop; req_o only in REQ.
REQ-025 Minimum per-flit period SHALL be 2 cycles plus ack synchronizer latency (ack_i edge to ack_s visible = 2 cycles).
REQ-026 Single-flit packet (head is last) SHALL follow IDLE->REQ->WAIT_ACK->WAIT_TAIL.
REQ-027 ack_i toggle while not in WAIT_ACK SHALL be ignored (protocol error, no state change).

Reset
REQ-028 On rst_i=1 at clock edge: state IDLE, FIFO empty, req_o=0, Data_o=0, PacketEnable_o=0, synchronizer flops 0, busy_o=0, flit_ready_o=1 from next cycle.
REQ-029 Reset mid-packet SHALL abandon the packet and drop FIFO contents; network side must be reset concurrently (req/ack phase realigned to 0).

Structure
REQ-030 SHALL place state enum tx_state_t and default WIDTH/DEPTH constants in shared package async_link_pkg.
REQ-031 SHALL instantiate one sub-module flit_fifo (synchronous, parameterised WIDTH+1 x DEPTH, full/empty flags).
REQ-032 Synchronizers SHALL be flop chains in this module, no combinational path from ack_i/Tailpassed_i to outputs.

Verification
REQ-033 Push 1 flit 0xA5A5A5A5 last=1, ack echoes req after 3 cycles, Tailpassed_i pulsed high then low -> req_o 0->1 once, Data_o=0xA5A5A5A5 before edge, PacketEnable_o 1 then 0, busy_o returns 0.
REQ-034 Push 4-flit packet 0x1..0x4 with immediate ack -> req_o toggles 4 times, Data_o sequence 1,2,3,4, each stable from pop until matching ack_s.
REQ-035 DEPTH=4, push 5 flits with ack_i held -> flit_ready_o=0 after 4 accepted; 5th accepted only after a pop.
REQ-036 Push head only, delay tail 10 cycles -> STALL, PacketEnable_o stays 1, req_o unchanged until tail pushed.
REQ-037 Assert rst_i in WAIT_ACK of flit 2 -> next cycle req_o=0, PacketEnable_o=0, FIFO empty, state IDLE.
REQ-038 Two back-to-back packets, Tailpassed_i held high 5 cycles -> second head not popped until tail_s returns 0.
